mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
Iterative multiply/divide unit that executes MIPS mult, multu, div and divu, and owns the HI/LO register pair. It sits beside the combinational ALU in the EX stage. Its width is a parameter, and it takes a fixed multi-cycle latency. It uses a start/busy/done handshake so the pipeline can stall while it runs. mthi and mtlo write HI/LO directly.

Parameters:
WIDTH, 32, operand and HI/LO width; must be even and ≥4.
CNT_WIDTH, 6, iteration counter width; must satisfy 2^CNT_WIDTH > WIDTH.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-high reset.
Start  input  1  request; sampled only when Busy=0.
MdOp  input  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo, 6/7=no-op.
A  input  WIDTH  multiplicand/dividend; also source for mthi/mtlo.
B  input  WIDTH  multiplier/divisor.
Busy  output  1  high while an operation is in flight.
Done  output  1  one-cycle pulse when HI/LO hold a new mul/div result.
DivZero  output  1  last div/divu had B=0; held until the next accepted mul/div.
HI  output  WIDTH  high product / remainder.
LO  output  WIDTH  low product / quotient.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: state=IDLE; Busy=0, Done=0, DivZero=0, HI=0, LO=0; counter=0. A reset mid-operation aborts it: HI/LO go to 0 and no Done is produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE, Start=1 with MdOp 0-3:
  - Latch the operation type.
  - For signed ops, latch |A| and |B| plus the sign flags. Sign of quotient = A[msb]^B[msb]; sign of remainder = A[msb].
  - For ops 2/3, set DivZero=(B==0); otherwise clear DivZero.
  - Counter=0; go to CALC; Busy=1 from the next cycle.
- IDLE, Start=1 with MdOp 4/5: HI (4) or LO (5) <= A on that edge. No Busy, no Done; stay in IDLE. DivZero is unchanged.
- IDLE, Start=1 with MdOp 6/7: ignored.
- CALC: WIDTH cycles, one radix-2 step per cycle.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract on magnitudes.
  - The counter increments each cycle; after step WIDTH-1, go to FIX.
- FIX (1 cycle): apply signs and write the result.
  - Signed mult: negate the 2*WIDTH product if signs differ.
  - Signed div: negate the quotient/remainder per their sign flags.
  - Divide by zero overrides the result: LO=all ones, HI=A as latched raw (not the magnitude), for both div and divu.
  - Write HI/LO; go to DONE.
- DONE (1 cycle): Done=1, Busy=0; go to IDLE. A Start in this cycle is ignored.
- Latency: with Start accepted at edge T, Busy is high in cycles T+1 through T+WIDTH+1. Done is high for exactly cycle T+WIDTH+2, and HI/LO show the new value from that cycle on.
- Start while Busy=1 or in DONE: ignored. HI, LO, MdOp latch and DivZero are all unaffected.
- Inputs A, B and MdOp may change freely after acceptance; only the latched copies are used.
- Signed overflow cases need no special handling:
  - MIN/-1 gives LO=MIN, HI=0.
  - MIN*MIN gives HI=0x40000000, LO=0 (WIDTH=32).
- HI/LO hold their values indefinitely between operations.

Test Plan (WIDTH=32):
1. multu A=0xFFFFFFFF, B=0xFFFFFFFF → Done exactly 34 cycles after the Start edge; HI=0xFFFFFFFE, LO=0x00000001; Busy high for 33 cycles.
2. mult A=0xFFFFFFFD (-3), B=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. div A=0xFFFFFFF9 (-7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. div A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0, DivZero=0.
3. divu A=100, B=0 → LO=0xFFFFFFFF, HI=0x00000064, DivZero=1. Then multu 2×3 → DivZero=0, HI=0, LO=6.
4. Start divu 10/3. Pulse Start with mult 7×7 in the 5th busy cycle, and again in the DONE cycle → only LO=3, HI=1 appears; one Done pulse total.
5. mthi A=0x12345678, then next cycle mtlo A=0x9ABCDEF0 → HI/LO updated one edge later each; Done and Busy stay 0.
6. Start multu 0xFFFF×0xFFFF; assert rst for 1 cycle at busy cycle 10 → Busy, Done, HI, LO = 0 next cycle, and no Done follows. A new divu 9/4 then gives LO=2, HI=1 with normal latency.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit that owns the HI/LO pair.
// Radix-2 shift-add multiply and restoring divide on magnitudes; signs are fixed up in a final cycle.
module mul_div_unit #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [2:0]       MdOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t state, state_next;

    logic [CNT_WIDTH-1:0] cnt;
    logic                 is_div;
    logic                 neg_main;
    logic                 neg_rem;
    logic [WIDTH-1:0]     opd;
    logic [WIDTH-1:0]     a_raw;
    logic [WIDTH-1:0]     acc_hi;
    logic [WIDTH-1:0]     acc_lo;

    logic                 accept;
    logic                 last_step;
    logic                 op_signed;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_diff;
    logic [2*WIDTH-1:0]   prod;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    assign accept    = (state == IDLE) && Start && !MdOp[2];
    assign last_step = (cnt == CNT_WIDTH'(WIDTH - 1));

    // mult (0) and div (2) are the signed ops
    assign op_signed = !MdOp[0];
    assign a_neg     = op_signed && A[WIDTH-1];
    assign b_neg     = op_signed && B[WIDTH-1];
    assign a_mag     = a_neg ? -A : A;
    assign b_mag     = b_neg ? -B : B;

    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : '0);
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opd});
    assign div_diff  = div_shift[WIDTH-1:0] - opd;

    assign prod      = {acc_hi, acc_lo};
    assign prod_fix  = neg_main ? -prod : prod;
    assign quo_fix   = neg_main ? -acc_lo : acc_lo;
    assign rem_fix   = neg_rem ? -acc_hi : acc_hi;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                Busy = 1'b1;
                if (last_step) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                Busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                Done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            opd      <= '0;
            a_raw    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            DivZero  <= 1'b0;
            HI       <= '0;
            LO       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        is_div   <= MdOp[1];
                        neg_main <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        a_raw    <= A;
                        cnt      <= '0;
                        DivZero  <= MdOp[1] && (B == '0);
                        acc_hi   <= '0;
                        // dividend / multiplier sit in the low half and shift out as they are consumed
                        if (MdOp[1]) begin
                            acc_lo <= a_mag;
                            opd    <= b_mag;
                        end else begin
                            acc_lo <= b_mag;
                            opd    <= a_mag;
                        end
                    end else if (Start && MdOp == 3'd4) begin
                        HI <= A;
                    end else if (Start && MdOp == 3'd5) begin
                        LO <= A;
                    end
                end
                CALC: begin
                    cnt <= cnt + CNT_WIDTH'(1);
                    if (is_div) begin
                        if (div_ge) begin
                            {acc_hi, acc_lo} <= {div_diff, acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            {acc_hi, acc_lo} <= {div_shift[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    if (is_div) begin
                        if (DivZero) begin
                            LO <= '1;
                            HI <= a_raw;
                        end else begin
                            LO <= quo_fix;
                            HI <= rem_fix;
                        end
                    end else begin
                        {HI, LO} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes expected HI/LO/DivZero and Done timing,
// an independent monitor pops and compares on every Done pulse.
module tb_mul_div_unit;

    localparam int WIDTH = 32;

    typedef struct {
        logic [WIDTH-1:0] hi;
        logic [WIDTH-1:0] lo;
        logic             dz;
        int               done_edge;
        string            name;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [2:0]       md_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    exp_t sb[$];
    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   busy_cnt;

    mul_div_unit #(.WIDTH(WIDTH), .CNT_WIDTH(6)) dut (
        .clk    (clk),
        .rst    (rst),
        .Start  (start),
        .MdOp   (md_op),
        .A      (a),
        .B      (b),
        .Busy   (busy),
        .Done   (done),
        .DivZero(div_zero),
        .HI     (hi),
        .LO     (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic void checkOutput(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endfunction

    // Every Done must match the oldest outstanding operation, including its cycle
    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            if (sb.size() == 0) begin
                n_checks++;
                $display("[TB] FAIL unexpected_done: got Done=1 at edge %0d, expected no Done", edge_cnt);
            end else begin
                e = sb.pop_front();
                checkOutput({e.name, "_hi"}, hi, e.hi);
                checkOutput({e.name, "_lo"}, lo, e.lo);
                checkOutput({e.name, "_divzero"}, div_zero, e.dz);
                checkOutput({e.name, "_done_edge"}, edge_cnt, e.done_edge);
            end
        end
    end

    task automatic waitDone(input string name, output int nbusy);
        bit seen = 0;
        nbusy = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) seen = 1;
        end
        if (!seen) begin
            n_checks++;
            $display("[TB] FAIL %s_timeout: got no Done in 100 cycles, expected Done", name);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [WIDTH-1:0] av,
                                 input logic [WIDTH-1:0] bv, input logic [WIDTH-1:0] ehi,
                                 input logic [WIDTH-1:0] elo, input logic edz,
                                 input string name, output int nbusy);
        @(posedge clk);
        #1;
        start = 1'b1;
        md_op = op;
        a     = av;
        b     = bv;
        sb.push_back('{ehi, elo, edz, edge_cnt + WIDTH + 2, name});
        @(posedge clk);
        #1;
        start = 1'b0;
        md_op = 3'd6;
        a     = ~av;
        b     = ~bv;
        waitDone(name, nbusy);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        md_op = 3'd6;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_divzero", div_zero, 0);
        checkOutput("reset_hi", hi, 0);
        checkOutput("reset_lo", lo, 0);

        applyStimulus(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0,
                      "multu_max", busy_cnt);
        checkOutput("multu_max_busy_cycles", busy_cnt, 33);

        applyStimulus(3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0,
                      "mult_neg3x5", busy_cnt);
        applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0,
                      "div_neg7by2", busy_cnt);
        applyStimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0,
                      "div_min_by_neg1", busy_cnt);
        applyStimulus(3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0,
                      "mult_min_x_min", busy_cnt);

        applyStimulus(3'd3, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1,
                      "divu_by_zero", busy_cnt);
        applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1,
                      "div_neg_by_zero", busy_cnt);
        applyStimulus(3'd1, 32'd2, 32'd3, 32'h0, 32'd6, 1'b0, "multu_2x3", busy_cnt);

        // Starts while busy and in the DONE cycle must be ignored
        @(posedge clk);
        #1;
        start = 1'b1;
        md_op = 3'd3;
        a     = 32'd10;
        b     = 32'd3;
        sb.push_back('{32'd1, 32'd3, 1'b0, edge_cnt + WIDTH + 2, "divu_10by3"});
        @(posedge clk);
        #1;
        start = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (busy && busy_cnt == 5) begin
                start = 1'b1;
                md_op = 3'd0;
                a     = 32'd7;
                b     = 32'd7;
                @(posedge clk);
                #1;
                start = 1'b0;
            end else if (done) begin
                start = 1'b1;
                md_op = 3'd0;
                a     = 32'd7;
                b     = 32'd7;
                @(posedge clk);
                #1;
                start = 1'b0;
                @(negedge clk);
                checkOutput("start_in_done_busy", busy, 0);
                checkOutput("start_in_done_done", done, 0);
                break;
            end
        end
        repeat (40) @(negedge clk);
        checkOutput("ignored_starts_hi", hi, 32'd1);
        checkOutput("ignored_starts_lo", lo, 32'd3);

        @(posedge clk);
        #1;
        start = 1'b1;
        md_op = 3'd4;
        a     = 32'h1234_5678;
        @(posedge clk);
        #1;
        md_op = 3'd5;
        a     = 32'h9ABC_DEF0;
        @(negedge clk);
        checkOutput("mthi_hi", hi, 32'h1234_5678);
        checkOutput("mthi_lo_unchanged", lo, 32'd3);
        checkOutput("mthi_busy", busy, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        md_op = 3'd6;
        @(negedge clk);
        checkOutput("mtlo_lo", lo, 32'h9ABC_DEF0);
        checkOutput("mtlo_hi_kept", hi, 32'h1234_5678);
        checkOutput("mtlo_busy", busy, 0);
        checkOutput("mtlo_done", done, 0);

        // Reset mid-operation: nothing pushed, so any later Done is flagged by the monitor
        @(posedge clk);
        #1;
        start = 1'b1;
        md_op = 3'd1;
        a     = 32'h0000_FFFF;
        b     = 32'h0000_FFFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 20 && busy_cnt < 10; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        checkOutput("abort_reached_busy10", busy_cnt, 10);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_hi", hi, 0);
        checkOutput("abort_lo", lo, 0);
        repeat (40) @(negedge clk);

        applyStimulus(3'd3, 32'd9, 32'd4, 32'd1, 32'd2, 1'b0, "divu_9by4", busy_cnt);
        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
